port_wr_backend: RTL and testbench
==================================

// Module: port_wr_backend
// PURPOSE
//  Downstream stage of the port write front-end. Takes the half-word stream
//  (xfer_data_vld/xfer_data/end_of_packet) and writes it into the shared packet
//  SRAM in 8-half-word pages. Pulls pages from the free-page allocator and links
//  them in the jump table. Emits one packet descriptor per packet to the port queue.
// PARAMETERS
//  PAGE_W   11       page index width (2048 pages; SRAM address = {page, 3-bit offset})
//  NULL_PG  2047     jump-table terminator written after the tail page
// PORTS
//  clk            in   1        clock
//  rst_n          in   1        async active-low reset
//  xfer_data_vld  in   1        half-word valid from front-end; no backpressure, accepted every cycle
//  xfer_data      in   16       half-word payload
//  end_of_packet  in   1        qualifies the last half-word of the packet (only with xfer_data_vld)
//  new_dest_port  in   4        dest port, sampled on the first half-word of a packet
//  new_length     in   9        declared length in half-words, sampled with new_dest_port
//  fp_req         out  1        free-page request, held high until fp_gnt
//  fp_gnt         in   1        allocator grant, 1-cycle pulse
//  fp_page        in   PAGE_W   granted page, valid with fp_gnt
//  sram_wr_en     out  1        SRAM write strobe
//  sram_wr_addr   out  PAGE_W+3 {page, offset}
//  sram_wr_data   out  16       data to SRAM
//  jt_wr_en       out  1        jump-table write strobe
//  jt_wr_addr     out  PAGE_W   page being linked
//  jt_wr_data     out  PAGE_W   next page, or NULL_PG
//  desc_vld       out  1        descriptor pulse, 1 cycle
//  desc_head      out  PAGE_W   first page of the packet
//  desc_tail      out  PAGE_W   last page of the packet
//  desc_dest      out  4        destination port
//  desc_len       out  9        counted half-words (saturates at 511)
//  desc_err       out  1        packet dropped or length mismatch; consumer frees its pages
// BEHAVIOUR
//  Reset: every output 0; spare_vld=0; state IDLE; offset=0. After reset, fp_req rises the first cycle.
//  Spare page: one-entry prefetch register. fp_req=~spare_vld. On fp_gnt: spare<=fp_page,
//   spare_vld<=1. Consume and refill in the same cycle: spare takes fp_page and stays valid.
//  States: IDLE, ACTIVE, DROP.
//  IDLE + vld: with spare_vld, head=cur=spare, consume spare, write offset 0, latch dest/len,
//   count=1, go to ACTIVE. Without spare_vld, go to DROP and set err.
//  ACTIVE + vld: write {cur,offset}; offset++ (wraps 7->0); count++.
//   If offset==7 and not eop, a page change is needed:
//    - spare_vld: jt[cur]<=spare in the same cycle, cur<=spare, consume spare.
//    - no spare: err=1, go to DROP; later half-words are not written.
//  Eop on any half-word (including a single-half-word packet from IDLE):
//   - write the half-word, then jt[cur]<=NULL_PG;
//   - desc_vld fires next cycle with head, tail=cur, dest, len=count;
//   - desc_err = err | (count != latched new_length);
//   - return to IDLE, offset<=0.
//   When eop coincides with offset==7, eop wins: no spare is consumed and no link is made.
//  DROP: absorbs half-words with no SRAM or JT writes. On eop, emits a descriptor with err=1
//   (head/tail are the pages allocated so far; head=NULL_PG if none), then goes to IDLE.
//  Latency: SRAM write is registered, 1 cycle after xfer_data_vld.
//   The eop JT terminator and desc_vld appear 1 cycle after the eop half-word.
//  jt_wr_en and the eop terminator never occur in the same cycle.
//   The link write uses the page-change cycle; the terminator uses the cycle after eop.
//  Back-to-back packets: a new first half-word may arrive the cycle after eop.
//   Its SRAM write may coincide with the previous desc_vld; both are legal.
//  Reset mid-packet: state, spare and counters clear; no descriptor; pages in flight are leaked.
//   Allocator reset reclaims them.
// TESTING
//  1. 8-hw packet, pages granted 5,9: writes addr 40..47; JT[5]=NULL; desc head=5 tail=5 len=8 err=0.
//  2. 20-hw packet, grants 3,4,6: JT[3]=4, JT[4]=6, JT[6]=NULL; desc head=3 tail=6 len=20.
//  3. 1-hw packet (sop+eop same hw), declared length 1: desc head=tail=spare, len=1, err=0.
//  4. fp_gnt withheld at the page boundary of a 12-hw packet: DROP after hw 8.
//     No writes for hw 9..12; desc_err=1.
//  5. Declared length 10, 9 hw sent: desc len=9, desc_err=1.
//     Back-to-back next packet is accepted the following cycle.
//  6. rst_n low mid-packet: all outputs 0 immediately; no desc_vld; fp_req high after release.

Source files
------------

// File: rtl/port_wr_backend.sv
// port_wr_backend
//   Back end of the port write path. Takes the half-word stream from the
//   front-end and writes it into the shared packet SRAM in 8-half-word pages.
//   Pages come from the free-page allocator through a one-entry spare
//   register. Pages are chained in the jump table, and the chain ends with
//   NULL_PG. One descriptor is emitted per packet.
//
// Ports
//   clk, rst_n                   clock, async active-low reset
//   xfer_data_vld/xfer_data      half-word stream (no backpressure)
//   end_of_packet                marks last half-word (with xfer_data_vld)
//   new_dest_port/new_length     packet header, sampled on first half-word
//   fp_req/fp_gnt/fp_page        free-page allocator handshake
//   sram_wr_en/addr/data         packet SRAM write port, addr = {page, offset}
//   jt_wr_en/addr/data           jump-table write port (link or NULL_PG)
//   desc_vld/head/tail/dest/len/err  packet descriptor, 1-cycle pulse
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for first half-word of a packet
// S_ACTIVE | writing packet half-words into cur page
// S_DROP   | no page was available; swallow the rest of the packet
module port_wr_backend #(
   parameter int                PAGE_W  = 11,
   parameter logic [PAGE_W-1:0] NULL_PG = {PAGE_W{1'b1}}
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                xfer_data_vld,
   input  logic [15:0]         xfer_data,
   input  logic                end_of_packet,
   input  logic [3:0]          new_dest_port,
   input  logic [8:0]          new_length,
   output logic                fp_req,
   input  logic                fp_gnt,
   input  logic [PAGE_W-1:0]   fp_page,
   output logic                sram_wr_en,
   output logic [PAGE_W+2:0]   sram_wr_addr,
   output logic [15:0]         sram_wr_data,
   output logic                jt_wr_en,
   output logic [PAGE_W-1:0]   jt_wr_addr,
   output logic [PAGE_W-1:0]   jt_wr_data,
   output logic                desc_vld,
   output logic [PAGE_W-1:0]   desc_head,
   output logic [PAGE_W-1:0]   desc_tail,
   output logic [3:0]          desc_dest,
   output logic [8:0]          desc_len,
   output logic                desc_err
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACTIVE = 2'd1;
   localparam logic [1:0] S_DROP   = 2'd2;

   logic [1:0]        state;
   logic [PAGE_W-1:0] spare;
   logic              spare_vld;
   logic [2:0]        offset;
   logic [PAGE_W-1:0] cur;
   logic [PAGE_W-1:0] head;
   logic [3:0]        dest;
   logic [8:0]        len_decl;
   logic [8:0]        count;

   logic              page_chg;
   logic              consume;
   logic              spare_vld_n;
   logic [8:0]        count_inc;

   always_comb begin
      // eop on the last slot of a page ends the packet; no page change
      page_chg    = (state == S_ACTIVE) & xfer_data_vld & (offset == 3'd7) & ~end_of_packet;
      consume     = xfer_data_vld & spare_vld & ((state == S_IDLE) | page_chg);
      spare_vld_n = fp_gnt | (spare_vld & ~consume);
      count_inc   = (count == 9'd511) ? count : count + 9'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         spare        <= '0;
         spare_vld    <= 1'b0;
         offset       <= 3'd0;
         cur          <= '0;
         head         <= '0;
         dest         <= 4'd0;
         len_decl     <= 9'd0;
         count        <= 9'd0;
         fp_req       <= 1'b0;
         sram_wr_en   <= 1'b0;
         sram_wr_addr <= '0;
         sram_wr_data <= 16'd0;
         jt_wr_en     <= 1'b0;
         jt_wr_addr   <= '0;
         jt_wr_data   <= '0;
         desc_vld     <= 1'b0;
         desc_head    <= '0;
         desc_tail    <= '0;
         desc_dest    <= 4'd0;
         desc_len     <= 9'd0;
         desc_err     <= 1'b0;
      end else begin
         sram_wr_en <= 1'b0;
         jt_wr_en   <= 1'b0;
         desc_vld   <= 1'b0;

         if (fp_gnt) spare <= fp_page;
         spare_vld <= spare_vld_n;
         // registered so fp_req is low in reset and rises on the first clock
         fp_req    <= ~spare_vld_n;

         if (xfer_data_vld) begin
            case (state)
               S_IDLE: begin
                  dest     <= new_dest_port;
                  len_decl <= new_length;
                  count    <= 9'd1;
                  if (spare_vld) begin
                     head         <= spare;
                     cur          <= spare;
                     sram_wr_en   <= 1'b1;
                     sram_wr_addr <= {spare, 3'd0};
                     sram_wr_data <= xfer_data;
                     if (end_of_packet) begin
                        jt_wr_en   <= 1'b1;
                        jt_wr_addr <= spare;
                        jt_wr_data <= NULL_PG;
                        desc_vld   <= 1'b1;
                        desc_head  <= spare;
                        desc_tail  <= spare;
                        desc_dest  <= new_dest_port;
                        desc_len   <= 9'd1;
                        desc_err   <= (new_length != 9'd1);
                        offset     <= 3'd0;
                     end else begin
                        offset <= 3'd1;
                        state  <= S_ACTIVE;
                     end
                  end else begin
                     head <= NULL_PG;
                     cur  <= NULL_PG;
                     if (end_of_packet) begin
                        desc_vld  <= 1'b1;
                        desc_head <= NULL_PG;
                        desc_tail <= NULL_PG;
                        desc_dest <= new_dest_port;
                        desc_len  <= 9'd1;
                        desc_err  <= 1'b1;
                     end else begin
                        state <= S_DROP;
                     end
                  end
               end

               S_ACTIVE: begin
                  sram_wr_en   <= 1'b1;
                  sram_wr_addr <= {cur, offset};
                  sram_wr_data <= xfer_data;
                  count        <= count_inc;
                  offset       <= offset + 3'd1;
                  if (end_of_packet) begin
                     jt_wr_en   <= 1'b1;
                     jt_wr_addr <= cur;
                     jt_wr_data <= NULL_PG;
                     desc_vld   <= 1'b1;
                     desc_head  <= head;
                     desc_tail  <= cur;
                     desc_dest  <= dest;
                     desc_len   <= count_inc;
                     desc_err   <= (count_inc != len_decl);
                     offset     <= 3'd0;
                     state      <= S_IDLE;
                  end else if (offset == 3'd7) begin
                     if (spare_vld) begin
                        jt_wr_en   <= 1'b1;
                        jt_wr_addr <= cur;
                        jt_wr_data <= spare;
                        cur        <= spare;
                     end else begin
                        state <= S_DROP;
                     end
                  end
               end

               S_DROP: begin
                  count <= count_inc;
                  if (end_of_packet) begin
                     desc_vld  <= 1'b1;
                     desc_head <= head;
                     desc_tail <= cur;
                     desc_dest <= dest;
                     desc_len  <= count_inc;
                     desc_err  <= 1'b1;
                     offset    <= 3'd0;
                     state     <= S_IDLE;
                  end
               end

               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_port_wr_backend.sv
// tb_port_wr_backend
//   Drives packets and acts as the free-page allocator. A packet-level model
//   predicts every SRAM write, jump-table write and descriptor. Predictions are
//   queued and matched in order against what the design emits.
module tb_port_wr_backend;

   localparam int PAGE_W = 11;
   localparam logic [10:0] NULL_PG = 11'd2047;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        xfer_data_vld = 1'b0;
   logic [15:0] xfer_data = 16'd0;
   logic        end_of_packet = 1'b0;
   logic [3:0]  new_dest_port = 4'd0;
   logic [8:0]  new_length = 9'd0;
   logic        fp_req;
   logic        fp_gnt = 1'b0;
   logic [10:0] fp_page = 11'd0;
   logic        sram_wr_en;
   logic [13:0] sram_wr_addr;
   logic [15:0] sram_wr_data;
   logic        jt_wr_en;
   logic [10:0] jt_wr_addr;
   logic [10:0] jt_wr_data;
   logic        desc_vld;
   logic [10:0] desc_head;
   logic [10:0] desc_tail;
   logic [3:0]  desc_dest;
   logic [8:0]  desc_len;
   logic        desc_err;

   port_wr_backend #(.PAGE_W(PAGE_W), .NULL_PG(NULL_PG)) dut (
      .clk(clk), .rst_n(rst_n),
      .xfer_data_vld(xfer_data_vld), .xfer_data(xfer_data),
      .end_of_packet(end_of_packet), .new_dest_port(new_dest_port),
      .new_length(new_length), .fp_req(fp_req), .fp_gnt(fp_gnt),
      .fp_page(fp_page), .sram_wr_en(sram_wr_en), .sram_wr_addr(sram_wr_addr),
      .sram_wr_data(sram_wr_data), .jt_wr_en(jt_wr_en), .jt_wr_addr(jt_wr_addr),
      .jt_wr_data(jt_wr_data), .desc_vld(desc_vld), .desc_head(desc_head),
      .desc_tail(desc_tail), .desc_dest(desc_dest), .desc_len(desc_len),
      .desc_err(desc_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // expected output queues
   logic [29:0] q_sram[$];   // {addr, data}
   logic [21:0] q_jt[$];     // {addr, data}
   logic [35:0] q_desc[$];   // {head, tail, dest, len, err}
   logic [10:0] forced_pg[$];

   // model of the allocator-facing spare page and the packet in flight
   logic        m_run = 1'b0;
   logic        m_spare_vld = 1'b0;
   logic [10:0] m_spare = 11'd0;
   logic        m_in_pkt = 1'b0;
   logic        m_drop = 1'b0;
   logic [10:0] m_pages[$];
   int          m_cnt = 0;
   logic [3:0]  m_dest = 4'd0;
   logic [8:0]  m_decl = 9'd0;

   int gnt_max = 0;
   logic gnt_hold = 1'b0;

   task automatic model_hw(input logic [15:0] d, input logic e,
                           input logic [3:0] dst, input logic [8:0] l);
      int idx;
      int len;
      logic [10:0] hd;
      logic [10:0] tl;
      if (!m_in_pkt) begin
         m_in_pkt = 1'b1;
         m_pages.delete();
         m_cnt  = 0;
         m_dest = dst;
         m_decl = l;
         m_drop = 1'b0;
         if (m_spare_vld) begin
            m_pages.push_back(m_spare);
            m_spare_vld = 1'b0;
         end else m_drop = 1'b1;
      end
      idx = m_cnt;
      m_cnt++;
      if (!m_drop) q_sram.push_back({m_pages[m_pages.size()-1], 3'(idx % 8), d});
      if (e) begin
         if (!m_drop) q_jt.push_back({m_pages[m_pages.size()-1], NULL_PG});
         len = (m_cnt > 511) ? 511 : m_cnt;
         hd  = (m_pages.size() == 0) ? NULL_PG : m_pages[0];
         tl  = (m_pages.size() == 0) ? NULL_PG : m_pages[m_pages.size()-1];
         q_desc.push_back({hd, tl, m_dest, 9'(len), (m_drop || (9'(len) != m_decl))});
         m_in_pkt = 1'b0;
      end else if (!m_drop && (idx % 8 == 7)) begin
         if (m_spare_vld) begin
            q_jt.push_back({m_pages[m_pages.size()-1], m_spare});
            m_pages.push_back(m_spare);
            m_spare_vld = 1'b0;
         end else m_drop = 1'b1;
      end
   endtask

   // called just after a falling edge; returns just after the next one
   task automatic step(input logic v, input logic e, input logic [3:0] dst, input logic [8:0] l);
      logic exp_req;
      logic g;
      logic [10:0] pg;
      exp_req = m_run && !m_spare_vld;
      check_val("fp_req", fp_req, exp_req);
      g  = exp_req && !gnt_hold && ($urandom_range(0, gnt_max) == 0);
      pg = 11'd0;
      if (g) begin
         if (forced_pg.size() != 0) pg = forced_pg.pop_front();
         else pg = 11'($urandom_range(0, 2046));
      end
      xfer_data_vld = v;
      end_of_packet = v & e;
      xfer_data     = v ? 16'($urandom) : 16'd0;
      new_dest_port = dst;
      new_length    = l;
      fp_gnt        = g;
      fp_page       = pg;
      if (v) model_hw(xfer_data, e, dst, l);
      if (g) begin
         m_spare = pg;
         m_spare_vld = 1'b1;
      end
      m_run = 1'b1;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 9'd0);
   endtask

   task automatic ensure_spare();
      int k;
      k = 0;
      while (!m_spare_vld && k < 100) begin
         idle(1);
         k++;
      end
      if (!m_spare_vld) check_val("spare_timeout", 1, 0);
   endtask

   task automatic send_pkt(input int n, input logic [8:0] decl, input logic [3:0] dst,
                           input int gap, input logic hold);
      for (int i = 0; i < n; i++) begin
         step(1'b1, (i == n - 1), dst, decl);
         if (i == 0 && hold) gnt_hold = 1'b1;
      end
      gnt_hold = 1'b0;
      idle(gap);
   endtask

   task automatic check_all_zero(input string tag);
      check_val(tag, {fp_req, sram_wr_en, sram_wr_addr, sram_wr_data, jt_wr_en,
                      jt_wr_addr, jt_wr_data, desc_vld, desc_head, desc_tail,
                      desc_dest, desc_len, desc_err}, 128'd0);
   endtask

   task automatic do_reset();
      xfer_data_vld = 1'b0;
      end_of_packet = 1'b0;
      fp_gnt = 1'b0;
      rst_n = 1'b0;
      #1;
      check_all_zero("reset_outputs");
      m_run = 1'b0;
      m_spare_vld = 1'b0;
      m_in_pkt = 1'b0;
      q_sram.delete();
      q_jt.delete();
      q_desc.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   always @(posedge clk) begin
      #1;
      if (rst_n) begin
         if (sram_wr_en) begin
            if (q_sram.size() == 0) check_val("sram_unexpected", {sram_wr_addr, sram_wr_data}, 0);
            else check_val("sram_write", {sram_wr_addr, sram_wr_data}, q_sram.pop_front());
         end
         if (jt_wr_en) begin
            if (q_jt.size() == 0) check_val("jt_unexpected", {jt_wr_addr, jt_wr_data}, 0);
            else check_val("jt_write", {jt_wr_addr, jt_wr_data}, q_jt.pop_front());
         end
         if (desc_vld) begin
            if (q_desc.size() == 0)
               check_val("desc_unexpected", {desc_head, desc_tail, desc_dest, desc_len, desc_err}, 0);
            else
               check_val("descriptor", {desc_head, desc_tail, desc_dest, desc_len, desc_err},
                         q_desc.pop_front());
         end
      end
   end

   initial begin
      @(negedge clk);
      do_reset();

      // 8 half-words on pages 5 then 9: eop on the last slot, no link
      gnt_max = 0;
      forced_pg.push_back(11'd5);
      forced_pg.push_back(11'd9);
      ensure_spare();
      send_pkt(8, 9'd8, 4'd2, 3, 1'b0);

      // 20 half-words over pages 3, 4, 6
      do_reset();
      forced_pg.push_back(11'd3);
      forced_pg.push_back(11'd4);
      forced_pg.push_back(11'd6);
      ensure_spare();
      send_pkt(20, 9'd20, 4'd7, 3, 1'b0);

      // single half-word packet
      ensure_spare();
      send_pkt(1, 9'd1, 4'd1, 2, 1'b0);

      // allocator withheld at the first page boundary of a 12-hw packet
      ensure_spare();
      send_pkt(12, 9'd12, 4'd3, 3, 1'b1);

      // short packet then back-to-back successor
      ensure_spare();
      send_pkt(9, 9'd10, 4'd4, 0, 1'b0);
      send_pkt(5, 9'd5, 4'd5, 3, 1'b0);

      // length counter saturation
      ensure_spare();
      send_pkt(520, 9'd511, 4'd6, 3, 1'b0);

      // packet arriving with no spare page at all
      ensure_spare();
      send_pkt(1, 9'd1, 4'd8, 0, 1'b1);
      gnt_hold = 1'b1;
      send_pkt(3, 9'd3, 4'd9, 0, 1'b0);
      gnt_hold = 1'b0;
      idle(3);

      // reset in the middle of a packet
      ensure_spare();
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'd10, 9'd30);
      do_reset();
      idle(2);

      // randomized traffic
      for (int p = 0; p < 40; p++) begin
         int n;
         int decl;
         n = $urandom_range(1, 40);
         decl = n;
         if ($urandom_range(0, 3) == 0) decl = n + $urandom_range(0, 2) - 1;
         gnt_max = $urandom_range(0, 6);
         send_pkt(n, 9'(decl), 4'($urandom), $urandom_range(0, 2), 1'b0);
      end

      gnt_max = 0;
      idle(6);
      check_val("sram_left", q_sram.size(), 0);
      check_val("jt_left", q_jt.size(), 0);
      check_val("desc_left", q_desc.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
